// File: rtl/mips_dp_pkg.sv
// Shared types for the MIPS integer datapath: ALU encodings, pipeline register
// layouts and width constants.
package mips_dp_pkg;

   localparam int XLEN     = 32;
   localparam int REG_AW   = 5;
   localparam int NUM_REGS = 32;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_OR  = 2'b11
   } alu_op_e;

   typedef struct packed {
      logic [XLEN-1:0]   rd_a;
      logic [XLEN-1:0]   rd_b;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] dest;
      logic              reg_wr;
      logic              alu_src;
      alu_op_e           alu_op;
      logic              mem_wr;
      logic              mem_to_reg;
      logic              ex_fwd_a;
      logic              mem_fwd_a;
      logic              ex_fwd_b;
      logic              mem_fwd_b;
   } id_ex_t;

   typedef struct packed {
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   store_data;
      logic [REG_AW-1:0] dest;
      logic              reg_wr;
      logic              mem_wr;
      logic              mem_to_reg;
   } ex_mem_t;

   typedef struct packed {
      logic [XLEN-1:0]   alu_result;
      logic [XLEN-1:0]   mem_data;
      logic [REG_AW-1:0] dest;
      logic              reg_wr;
      logic              mem_to_reg;
   } mem_wb_t;

endpackage

// File: rtl/mips_datapath_if.sv
// Control/hazard-unit side of the datapath: instruction, control and forward
// selects in; sign-extended immediate, rs data and Zero back out.
interface mips_datapath_if;
   logic [31:0] Instructions;
   logic        RegDst;
   logic        RegWr;
   logic        ALUsrc;
   logic [1:0]  ALUcntrl;
   logic        MemWr;
   logic        MemToReg;
   logic        ex_forward_a;
   logic        mem_forward_a;
   logic        ex_forward_b;
   logic        mem_forward_b;
   logic [31:0] seOut;
   logic [31:0] reg_Da;
   logic        Zero;

   modport master (
      output Instructions, RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg,
      output ex_forward_a, mem_forward_a, ex_forward_b, mem_forward_b,
      input  seOut, reg_Da, Zero
   );

   modport slave (
      input  Instructions, RegDst, RegWr, ALUsrc, ALUcntrl, MemWr, MemToReg,
      input  ex_forward_a, mem_forward_a, ex_forward_b, mem_forward_b,
      output seOut, reg_Da, Zero
   );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file, 2 async reads, 1 sync write, $0 hardwired to zero.
// DATAPATH_WB_BYPASS_EN makes reads return the data being written this cycle.
module mips_regfile
   import mips_dp_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] ra,
   input  logic [REG_AW-1:0] rb,
   input  logic              we,
   input  logic [REG_AW-1:0] wa,
   input  logic [XLEN-1:0]   wd,
   output logic [XLEN-1:0]   da,
   output logic [XLEN-1:0]   db
);

   logic [XLEN-1:0] regs_reg [NUM_REGS];
   logic            wr_en;

   // A reset cycle discards the instruction sitting in WB
   assign wr_en = we && !rst && (wa != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_reg[i] <= '0;
         end
      end else if (wr_en) begin
         regs_reg[wa] <= wd;
      end
   end

   always_comb begin
      da = (ra == '0) ? '0 : regs_reg[ra];
      db = (rb == '0) ? '0 : regs_reg[rb];
`ifdef DATAPATH_WB_BYPASS_EN
      if (wr_en && (wa == ra)) da = wd;
      if (wr_en && (wa == rb)) db = wd;
`endif
   end

endmodule

// File: rtl/mips_datapath.sv
// ID/EX/MEM/WB integer datapath: register file, ALU, data memory, pipeline regs.
// Optional WB write-through in the register file via DATAPATH_WB_BYPASS_EN.
module mips_datapath
   import mips_dp_pkg::*;
#(
   parameter int DMEM_WORDS = 64
) (
   input  logic          clk,
   input  logic          rst,
   mips_datapath_if.slave dp
);

   localparam int DMEM_AW = $clog2(DMEM_WORDS);

   id_ex_t  id_ex_reg;
   ex_mem_t ex_mem_reg;
   mem_wb_t mem_wb_reg;

   logic [XLEN-1:0]    rd_b;
   logic [XLEN-1:0]    se_imm;
   logic [XLEN-1:0]    wb_data;
   logic [XLEN-1:0]    op_a;
   logic [XLEN-1:0]    op_b;
   logic [XLEN-1:0]    alu_b;
   logic [XLEN-1:0]    alu_result;
   logic [XLEN-1:0]    mem_rdata;
   logic [DMEM_AW-1:0] mem_addr;
   logic [XLEN-1:0]    dmem_reg [DMEM_WORDS];
   logic               unused_opcode;

   assign unused_opcode = ^dp.Instructions[31:26];

   assign se_imm   = {{16{dp.Instructions[15]}}, dp.Instructions[15:0]};
   assign dp.seOut = se_imm;

   mips_regfile u_regfile (
      .clk (clk),
      .rst (rst),
      .ra  (dp.Instructions[25:21]),
      .rb  (dp.Instructions[20:16]),
      .we  (mem_wb_reg.reg_wr),
      .wa  (mem_wb_reg.dest),
      .wd  (wb_data),
      .da  (dp.reg_Da),
      .db  (rd_b)
   );

   assign wb_data = mem_wb_reg.mem_to_reg ? mem_wb_reg.mem_data : mem_wb_reg.alu_result;

   // EX-stage operand select: the younger producer (EX/MEM) wins over MEM/WB
   always_comb begin
      op_a = id_ex_reg.rd_a;
      if (id_ex_reg.ex_fwd_a)       op_a = ex_mem_reg.alu_result;
      else if (id_ex_reg.mem_fwd_a) op_a = wb_data;

      op_b = id_ex_reg.rd_b;
      if (id_ex_reg.ex_fwd_b)       op_b = ex_mem_reg.alu_result;
      else if (id_ex_reg.mem_fwd_b) op_b = wb_data;

      alu_b = id_ex_reg.alu_src ? id_ex_reg.imm : op_b;

      alu_result = op_a + alu_b;
      case (id_ex_reg.alu_op)
         ALU_ADD: alu_result = op_a + alu_b;
         ALU_SUB: alu_result = op_a - alu_b;
         ALU_AND: alu_result = op_a & alu_b;
         ALU_OR:  alu_result = op_a | alu_b;
         default: alu_result = op_a + alu_b;
      endcase
   end

   assign dp.Zero = (alu_result == '0);

   assign mem_addr  = ex_mem_reg.alu_result[DMEM_AW+1:2];
   assign mem_rdata = dmem_reg[mem_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            dmem_reg[i] <= '0;
         end
      end else if (ex_mem_reg.mem_wr) begin
         dmem_reg[mem_addr] <= ex_mem_reg.store_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         id_ex_reg  <= '0;
         ex_mem_reg <= '0;
         mem_wb_reg <= '0;
      end else begin
         id_ex_reg.rd_a       <= dp.reg_Da;
         id_ex_reg.rd_b       <= rd_b;
         id_ex_reg.imm        <= se_imm;
         id_ex_reg.dest       <= dp.RegDst ? dp.Instructions[15:11] : dp.Instructions[20:16];
         id_ex_reg.reg_wr     <= dp.RegWr;
         id_ex_reg.alu_src    <= dp.ALUsrc;
         id_ex_reg.alu_op     <= alu_op_e'(dp.ALUcntrl);
         id_ex_reg.mem_wr     <= dp.MemWr;
         id_ex_reg.mem_to_reg <= dp.MemToReg;
         id_ex_reg.ex_fwd_a   <= dp.ex_forward_a;
         id_ex_reg.mem_fwd_a  <= dp.mem_forward_a;
         id_ex_reg.ex_fwd_b   <= dp.ex_forward_b;
         id_ex_reg.mem_fwd_b  <= dp.mem_forward_b;

         ex_mem_reg.alu_result <= alu_result;
         ex_mem_reg.store_data <= op_b;
         ex_mem_reg.dest       <= id_ex_reg.dest;
         ex_mem_reg.reg_wr     <= id_ex_reg.reg_wr;
         ex_mem_reg.mem_wr     <= id_ex_reg.mem_wr;
         ex_mem_reg.mem_to_reg <= id_ex_reg.mem_to_reg;

         mem_wb_reg.alu_result <= ex_mem_reg.alu_result;
         mem_wb_reg.mem_data   <= mem_rdata;
         mem_wb_reg.dest       <= ex_mem_reg.dest;
         mem_wb_reg.reg_wr     <= ex_mem_reg.reg_wr;
         mem_wb_reg.mem_to_reg <= ex_mem_reg.mem_to_reg;
      end
   end

endmodule

// File: tb/tb_mips_datapath.sv
// Directed bench for mips_datapath: instruction-level model checked every cycle
// plus hand-computed literal expectations. Honours DATAPATH_WB_BYPASS_EN.
module tb_mips_datapath;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mips_datapath_if dp_if ();

   mips_datapath #(.DMEM_WORDS(64)) dut (
      .clk (clk),
      .rst (rst),
      .dp  (dp_if)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   // Instruction-level model: architectural registers/memory plus the three
   // older instructions still able to supply forwarded or written-back values.
   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wb;
      logic [4:0]  dest;
      logic        wr;
   } slot_t;

   slot_t       s1, s2, s3;
   logic [31:0] m_reg [32];
   logic [31:0] m_mem [64];

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] sext(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
`ifdef DATAPATH_WB_BYPASS_EN
      if (!rst && s3.wr && s3.dest == r) return s3.wb;
`endif
      return m_reg[r];
   endfunction

   task automatic model_edge();
      logic [31:0] a, b_reg, b, res, wbv;
      logic [5:0]  addr;
      if (rst) begin
         for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
         for (int i = 0; i < 64; i++) m_mem[i] = 32'd0;
         s1 = '0; s2 = '0; s3 = '0;
         return;
      end
      a     = dp_if.ex_forward_a ? s1.alu : dp_if.mem_forward_a ? s2.wb
            : m_read(dp_if.Instructions[25:21]);
      b_reg = dp_if.ex_forward_b ? s1.alu : dp_if.mem_forward_b ? s2.wb
            : m_read(dp_if.Instructions[20:16]);
      b     = dp_if.ALUsrc ? sext(dp_if.Instructions[15:0]) : b_reg;
      case (dp_if.ALUcntrl)
         2'b00:   res = a + b;
         2'b01:   res = a - b;
         2'b10:   res = a & b;
         default: res = a | b;
      endcase
      addr = res[7:2];
      wbv  = dp_if.MemToReg ? m_mem[addr] : res;
      if (dp_if.MemWr) m_mem[addr] = b_reg;
      if (s3.wr && s3.dest != 5'd0) m_reg[s3.dest] = s3.wb;
      s3 = s2;
      s2 = s1;
      s1.alu  = res;
      s1.wb   = wbv;
      s1.dest = dp_if.RegDst ? dp_if.Instructions[15:11] : dp_if.Instructions[20:16];
      s1.wr   = dp_if.RegWr;
   endtask

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check32("seOut", dp_if.seOut, sext(dp_if.Instructions[15:0]));
         check32("reg_Da", dp_if.reg_Da, m_read(dp_if.Instructions[25:21]));
         check32("Zero", {31'd0, dp_if.Zero}, {31'd0, s1.alu == 32'd0});
      end
   end

   function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
      return {6'd8, rs, rt, imm};
   endfunction

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   // fwd = {ex_forward_a, mem_forward_a, ex_forward_b, mem_forward_b}
   task automatic drive(input logic [31:0] instr, input logic regdst, input logic regwr,
                        input logic alusrc, input logic [1:0] aluc, input logic memwr,
                        input logic memtoreg, input logic [3:0] fwd);
      dp_if.Instructions  = instr;
      dp_if.RegDst        = regdst;
      dp_if.RegWr         = regwr;
      dp_if.ALUsrc        = alusrc;
      dp_if.ALUcntrl      = aluc;
      dp_if.MemWr         = memwr;
      dp_if.MemToReg      = memtoreg;
      dp_if.ex_forward_a  = fwd[3];
      dp_if.mem_forward_a = fwd[2];
      dp_if.ex_forward_b  = fwd[1];
      dp_if.mem_forward_b = fwd[0];
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(32'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);
         step();
      end
   endtask

   task automatic issue_i(input string name, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [15:0] imm, input logic regwr, input logic memwr,
                          input logic memtoreg);
      drive(itype(rs, rt, imm), 1'b0, regwr, 1'b1, 2'b00, memwr, memtoreg, 4'b0000);
      $display("t=%0t issue %s", $time, name);
      step();
   endtask

   task automatic issue_r(input string name, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [1:0] aluc, input logic regwr,
                          input logic [3:0] fwd);
      drive(rtype(rs, rt, rd), 1'b1, regwr, 1'b0, aluc, 1'b0, 1'b0, fwd);
      $display("t=%0t issue %s", $time, name);
      step();
   endtask

   task automatic peek(input string name, input logic [4:0] rs, input logic [31:0] exp);
      drive(itype(rs, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000);
      #1;
      check32(name, dp_if.reg_Da, exp);
      $display("t=%0t peek $%0d = %h", $time, rs, dp_if.reg_Da);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle(1);
      chk_en = 1'b1;
      idle(1);
      rst = 1'b0;
      check32("reset_Zero", {31'd0, dp_if.Zero}, 32'd1);
      peek("reset_r1", 5'd1, 32'd0);

      issue_i("addi $1,$0,2015", 5'd0, 5'd1, 16'd2015, 1'b1, 1'b0, 1'b0);
      idle(3);
      peek("addi_r1", 5'd1, 32'd2015);

      do_reset();
      issue_i("addi $1,$0,2015", 5'd0, 5'd1, 16'd2015, 1'b1, 1'b0, 1'b0);
      issue_i("addi $2,$0,404", 5'd0, 5'd2, 16'd404, 1'b1, 1'b0, 1'b0);
      issue_r("add $1,$1,$2", 5'd1, 5'd2, 5'd1, 2'b00, 1'b1, 4'b0110);
      idle(3);
      peek("fwd_add_r1", 5'd1, 32'd2419);
      peek("fwd_add_r2", 5'd2, 32'd404);

      issue_i("sw $1,4($0)", 5'd0, 5'd1, 16'd4, 1'b0, 1'b1, 1'b0);
      issue_i("lw $3,4($0)", 5'd0, 5'd3, 16'd4, 1'b1, 1'b0, 1'b1);
      idle(3);
      peek("lw_r3", 5'd3, 32'd2419);
      issue_i("lw $4,0($0)", 5'd0, 5'd4, 16'd0, 1'b1, 1'b0, 1'b1);
      idle(3);
      peek("lw_r4", 5'd4, 32'd0);

      drive(itype(5'd0, 5'd7, 16'hFFFF), 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000);
      #1;
      check32("seOut_neg", dp_if.seOut, 32'hFFFF_FFFF);
      $display("t=%0t issue addi $7,$0,-1", $time);
      step();
      check32("Zero_addi7", {31'd0, dp_if.Zero}, 32'd0);
      issue_r("sub $8,$7,$7", 5'd7, 5'd7, 5'd8, 2'b01, 1'b1, 4'b1010);
      check32("Zero_sub", {31'd0, dp_if.Zero}, 32'd1);
      idle(3);
      peek("addi_r7", 5'd7, 32'hFFFF_FFFF);
      peek("sub_r8", 5'd8, 32'd0);

      issue_i("addi $0,$0,5", 5'd0, 5'd0, 16'd5, 1'b1, 1'b0, 1'b0);
      idle(3);
      peek("r0_zero", 5'd0, 32'd0);

      issue_r("add $9,$1,$3", 5'd1, 5'd3, 5'd9, 2'b00, 1'b1, 4'b0000);
      rst = 1'b1;
      idle(1);
      check32("Zero_in_reset", {31'd0, dp_if.Zero}, 32'd1);
      rst = 1'b0;
      idle(3);
      peek("rst_r9", 5'd9, 32'd0);
      peek("rst_r1", 5'd1, 32'd0);
      peek("rst_r3", 5'd3, 32'd0);

      issue_i("addi $5,$0,77", 5'd0, 5'd5, 16'd77, 1'b1, 1'b0, 1'b0);
      idle(2);
      issue_r("add $6,$5,$0", 5'd5, 5'd0, 5'd6, 2'b00, 1'b1, 4'b0000);
      idle(3);
      peek("dist3_r5", 5'd5, 32'd77);
`ifdef DATAPATH_WB_BYPASS_EN
      peek("dist3_r6", 5'd6, 32'd77);
`else
      peek("dist3_r6", 5'd6, 32'd0);
`endif
      idle(1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
